// File: rtl/novacore_cfg_loader.sv
// Byte-stream configuration loader for the NovaCORE fabric: unpacks frames and
// drives the c_* fields with a registered strobe that has guaranteed setup/pulse/hold.
module novacore_cfg_loader #(
    parameter int BUS_W     = 42,
    parameter int UID_W     = 7,
    parameter int DIM_W     = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             cfg_restart,
    output logic             mode,
    output logic [BUS_W-1:0] c_bus,
    output logic [UID_W-1:0] c_uid,
    output logic [DIM_W-1:0] c_dimension,
    output logic             c_dimswitch,
    output logic             c_clk,
    output logic [15:0]      frames_done,
    output logic             busy
);

    localparam int PAY_N = (BUS_W + 7) / 8;
    localparam int PAY_W = PAY_N * 8;
    localparam int CNT_W = $clog2(PAY_N + 1);
    localparam int TMR_W = 8;

    localparam logic [2:0] HDR0  = 3'd0;
    localparam logic [2:0] HDR1  = 3'd1;
    localparam logic [2:0] PAY   = 3'd2;
    localparam logic [2:0] SETUP = 3'd3;
    localparam logic [2:0] PULSE = 3'd4;
    localparam logic [2:0] HOLD  = 3'd5;
    localparam logic [2:0] RUN   = 3'd6;

    logic [2:0]       state;
    logic [CNT_W-1:0] byte_cnt;
    logic [TMR_W-1:0] tmr;
    logic [UID_W-1:0] uid_q;
    logic [DIM_W-1:0] dim_q;
    logic             dsw_q;
    logic [PAY_W-9:0] pay_q;
    logic [PAY_W-1:0] pay_next;
    logic             accept;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign in_ready = (state == HDR0) || (state == HDR1) || (state == PAY);
    assign busy     = (state != RUN);
    assign accept   = in_valid && in_ready;
    // Bytes enter at the top so the first payload byte ends up least significant.
    assign pay_next = {in_data, pay_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HDR0;
            byte_cnt    <= '0;
            tmr         <= '0;
            uid_q       <= '0;
            dim_q       <= '0;
            dsw_q       <= 1'b0;
            pay_q       <= '0;
            mode        <= 1'b1;
            c_bus       <= '0;
            c_uid       <= '0;
            c_dimension <= '0;
            c_dimswitch <= 1'b0;
            c_clk       <= 1'b0;
            frames_done <= '0;
        end else begin
            case (state)
                HDR0: begin
                    if (accept) begin
                        if (in_data[7]) begin
                            mode  <= 1'b0;
                            state <= RUN;
                        end else begin
                            uid_q <= in_data[UID_W-1:0];
                            state <= HDR1;
                        end
                    end
                end
                HDR1: begin
                    if (accept) begin
                        dim_q    <= in_data[DIM_W-1:0];
                        dsw_q    <= in_data[2];
                        byte_cnt <= '0;
                        state    <= PAY;
                    end
                end
                PAY: begin
                    if (accept) begin
                        pay_q <= pay_next[PAY_W-1:8];
                        if (byte_cnt == CNT_W'(PAY_N - 1)) begin
                            // All fields move together so they share one setup window.
                            c_bus       <= pay_next[BUS_W-1:0];
                            c_uid       <= uid_q;
                            c_dimension <= dim_q;
                            c_dimswitch <= dsw_q;
                            tmr         <= '0;
                            state       <= SETUP;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                SETUP: begin
                    if (tmr == TMR_W'(SETUP_CYC - 1)) begin
                        tmr   <= '0;
                        c_clk <= 1'b1;
                        state <= PULSE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                PULSE: begin
                    if (tmr == TMR_W'(PULSE_CYC - 1)) begin
                        tmr   <= '0;
                        c_clk <= 1'b0;
                        state <= HOLD;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                HOLD: begin
                    if (tmr == TMR_W'(HOLD_CYC - 1)) begin
                        tmr         <= '0;
                        frames_done <= sat_inc(frames_done);
                        state       <= HDR0;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                RUN: begin
                    if (cfg_restart) begin
                        mode        <= 1'b1;
                        frames_done <= '0;
                        state       <= HDR0;
                    end
                end
                default: state <= HDR0;
            endcase
        end
    end

endmodule

// File: tb/tb_novacore_cfg_loader.sv
// Directed bench for novacore_cfg_loader: frames are queued on a scoreboard when
// driven and checked against the fabric-side fields on every c_clk pulse.
module tb_novacore_cfg_loader;

    localparam int BUS_W     = 42;
    localparam int UID_W     = 7;
    localparam int DIM_W     = 2;
    localparam int SETUP_CYC = 1;
    localparam int PULSE_CYC = 2;
    localparam int HOLD_CYC  = 1;

    logic             clk;
    logic             rst_n;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             cfg_restart;
    logic             mode;
    logic [BUS_W-1:0] c_bus;
    logic [UID_W-1:0] c_uid;
    logic [DIM_W-1:0] c_dimension;
    logic             c_dimswitch;
    logic             c_clk;
    logic [15:0]      frames_done;
    logic             busy;

    typedef struct packed {
        logic [BUS_W-1:0] bus;
        logic [UID_W-1:0] uid;
        logic [DIM_W-1:0] dim;
        logic             dsw;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    exp_t snap;
    exp_t last_f;
    exp_t e_pop;
    int   n_pass  = 0;
    int   n_total = 0;
    int   pulses  = 0;
    int   width   = 0;
    int   p0;
    logic prev_c  = 1'b0;

    novacore_cfg_loader #(
        .BUS_W(BUS_W), .UID_W(UID_W), .DIM_W(DIM_W),
        .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cfg_restart(cfg_restart), .mode(mode),
        .c_bus(c_bus), .c_uid(c_uid), .c_dimension(c_dimension),
        .c_dimswitch(c_dimswitch), .c_clk(c_clk), .frames_done(frames_done),
        .busy(busy)
    );

    assign cur = {c_bus, c_uid, c_dimension, c_dimswitch};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int k;
        if (gaps) begin
            for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("accept_wait", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [47:0] pay, input bit gaps, input int rs_idx);
        exp_t e;
        logic [7:0] b;
        e = {pay[BUS_W-1:0], b0[UID_W-1:0], b1[DIM_W-1:0], b1[2]};
        sb.push_back(e);
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      b = b0;
            else if (i == 1) b = b1;
            else             b = pay[8*(i-2) +: 8];
            if (i == rs_idx) cfg_restart = 1'b1;
            send_byte(b, gaps);
            cfg_restart = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("idle_wait", 64'(in_ready), 64'(1));
    endtask

    // Pulse monitor: fields must match the queued frame at the rise and stay put
    // through setup, pulse and hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_c = 1'b0;
            width  = 0;
        end else begin
            if (c_clk && !prev_c) begin
                pulses++;
                width = 1;
                chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    e_pop = sb.pop_front();
                    chk("fields_at_rise", 64'(cur), 64'(e_pop));
                    chk("fields_in_setup", 64'(last_f), 64'(e_pop));
                end
                snap = cur;
                chk("rdy_in_pulse", 64'(in_ready), 64'(0));
            end else if (c_clk) begin
                width++;
                chk("fields_in_pulse", 64'(cur), 64'(snap));
            end else if (prev_c) begin
                chk("pulse_width", 64'(width), 64'(PULSE_CYC));
                chk("fields_in_hold", 64'(cur), 64'(snap));
            end
            prev_c = c_clk;
            last_f = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        cfg_restart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mode", 64'(mode), 64'(1));
        chk("rst_c_clk", 64'(c_clk), 64'(0));
        chk("rst_c_bus", 64'(c_bus), 64'(0));
        chk("rst_c_uid", 64'(c_uid), 64'(0));
        chk("rst_frames", 64'(frames_done), 64'(0));
        chk("rst_busy", 64'(busy), 64'(1));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame with cycle-exact strobe timing.
        send_frame(8'h05, 8'h06, 48'h3F0504030201, 1'b0, -1);
        chk("t1_uid", 64'(c_uid), 64'(5));
        chk("t1_dim", 64'(c_dimension), 64'(2));
        chk("t1_dsw", 64'(c_dimswitch), 64'(1));
        chk("t1_bus", 64'(c_bus), 64'h0000_0305_0403_0201);
        chk("t1_clk_setup", 64'(c_clk), 64'(0));
        chk("t1_rdy_setup", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        chk("t1_clk_p1", 64'(c_clk), 64'(1));
        @(posedge clk); #1;
        chk("t1_clk_p2", 64'(c_clk), 64'(1));
        @(posedge clk); #1;
        chk("t1_clk_hold", 64'(c_clk), 64'(0));
        chk("t1_rdy_hold", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        chk("t1_rdy_back", 64'(in_ready), 64'(1));
        chk("t1_frames", 64'(frames_done), 64'(1));

        // END frame, then restart.
        chk("t2_mode_pre", 64'(mode), 64'(1));
        send_byte(8'h80, 1'b0);
        chk("t2_mode", 64'(mode), 64'(0));
        chk("t2_busy", 64'(busy), 64'(0));
        chk("t2_rdy", 64'(in_ready), 64'(0));
        chk("t2_bus_kept", 64'(c_bus), 64'h0000_0305_0403_0201);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_mode_run", 64'(mode), 64'(0));
        cfg_restart = 1'b1;
        @(posedge clk); #1;
        cfg_restart = 1'b0;
        chk("t2_mode_restart", 64'(mode), 64'(1));
        chk("t2_frames_clr", 64'(frames_done), 64'(0));
        chk("t2_rdy_restart", 64'(in_ready), 64'(1));
        chk("t2_busy_restart", 64'(busy), 64'(1));

        // Three frames with random valid gaps.
        p0 = pulses;
        send_frame(8'h12, 8'h01, 48'h0102030405A5, 1'b1, -1);
        send_frame(8'h7F, 8'h04, 48'h00FEDCBA9876, 1'b1, -1);
        send_frame(8'h33, 8'hFB, 48'hC0FFEE123456, 1'b1, -1);
        wait_idle();
        chk("t3_pulses", 64'(pulses - p0), 64'(3));
        chk("t3_frames", 64'(frames_done), 64'(3));

        // Payload bits above BUS_W, in_ready held low through the strobe.
        send_frame(8'h11, 8'h01, 48'hFF0504030201, 1'b0, -1);
        in_valid = 1'b1;
        in_data  = 8'h22;
        chk("t4_rdy_setup", 64'(in_ready), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t4_rdy_busy", 64'(in_ready), 64'(0));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t4_bus_top", 64'(c_bus[BUS_W-1:BUS_W-2]), 64'(3));
        chk("t4_frames", 64'(frames_done), 64'(4));

        // Restart request during payload is ignored.
        p0 = pulses;
        send_frame(8'h2A, 8'h03, 48'h665544332211, 1'b0, 3);
        wait_idle();
        chk("t5_pulses", 64'(pulses - p0), 64'(1));
        chk("t5_frames", 64'(frames_done), 64'(5));
        chk("t5_mode", 64'(mode), 64'(1));

        // Reset in the middle of a strobe.
        send_frame(8'h07, 8'h02, 48'h0A0B0C0D0E0F, 1'b0, -1);
        wait_idle();
        chk("t6_frames_pre", 64'(frames_done), 64'(6));
        send_frame(8'h08, 8'h05, 48'h111111111111, 1'b0, -1);
        @(posedge clk); #1;
        chk("t6_clk_pulse", 64'(c_clk), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_clk_async", 64'(c_clk), 64'(0));
        chk("t6_mode_async", 64'(mode), 64'(1));
        chk("t6_bus_async", 64'(c_bus), 64'(0));
        chk("t6_frames_async", 64'(frames_done), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        p0 = pulses;
        send_frame(8'h09, 8'h04, 48'hA1B2C3D4E5F6, 1'b0, -1);
        wait_idle();
        chk("t6_pulses", 64'(pulses - p0), 64'(1));
        chk("t6_frames", 64'(frames_done), 64'(1));
        chk("t6_uid", 64'(c_uid), 64'(9));
        chk("t6_sb_drained", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
